calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Key-driven calculator sequencer: operand entry, add (optionally subtract), BCD result display.
// Defining CALC_SUB_EN enables subtraction on key 11 and a signed result display.
module calc_sequencer #(
    parameter int unsigned MAX_DIGITS = 9
) (
    input  logic        CLK_100MHZ,
    input  logic        reset,
    input  logic        clicked,
    input  logic [4:0]  clickedMatrix,
    output logic [39:0] numActual,
    output logic [3:0]  counterTotal,
    output logic        negative,
    output logic        busy,
    output logic        error
);

`ifdef CALC_SUB_EN
    localparam logic SUB_EN = 1'b1;
`else
    localparam logic SUB_EN = 1'b0;
`endif
    localparam logic [35:0] DISP_MAX  = 36'd9_999_999_999;
    localparam logic [5:0]  LAST_ITER = 6'd34;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        OP      = 3'd1,
        ENTER_B = 3'd2,
        CONV    = 3'd3,
        RESULT  = 3'd4,
        ERR     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               click_prev_q, click_prev_d;
    logic signed [35:0] a_q, a_d, res_q, res_d;
    logic [29:0]        b_q, b_d;
    logic               op_sub_q, op_sub_d;
    logic [39:0]        num_q, num_d, bcd_q, bcd_d;
    logic [33:0]        bin_q, bin_d;
    logic [5:0]         iter_q, iter_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               neg_q, neg_d, busy_q, busy_d, err_q, err_d;

    logic               event_s, is_digit_s, is_op_s, is_eq_s, is_clr_s, digit_ok_s;
    logic               clear_s, new_a_s;
    logic [3:0]         digit_s;
    logic signed [35:0] sum_s, mag_s;
    logic               ovf_s;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
    function automatic logic [39:0] dabble_step(input logic [39:0] bcd, input logic bit_in);
        logic [39:0] adj;
        adj = bcd;
        for (int i = 0; i < 10; i++) begin
            adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        end
        return 40'({adj, bit_in});
    endfunction

    function automatic logic [3:0] sig_digits(input logic [39:0] bcd);
        logic [3:0] n;
        n = 4'd1;
        for (int i = 1; i < 10; i++) begin
            n = (bcd[i*4 +: 4] != 4'd0) ? 4'(i + 1) : n;
        end
        return n;
    endfunction

    assign event_s    = clicked & ~click_prev_q;
    assign digit_s    = clickedMatrix[3:0];
    assign is_digit_s = (clickedMatrix < 5'd10);
    assign is_op_s    = (clickedMatrix == 5'd10) || (SUB_EN && (clickedMatrix == 5'd11));
    assign is_eq_s    = (clickedMatrix == 5'd12);
    assign is_clr_s   = (clickedMatrix == 5'd13);
    assign digit_ok_s = (cnt_q != MAX_DIGITS[3:0]) && !((digit_s == 4'd0) && (cnt_q == 4'd0));

    assign sum_s = op_sub_q ? (a_q - $signed({6'd0, b_q})) : (a_q + $signed({6'd0, b_q}));
    assign mag_s = sum_s[35] ? -sum_s : sum_s;
    assign ovf_s = (mag_s > DISP_MAX);

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d      = state_q;
        click_prev_d = clicked;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        op_sub_d     = op_sub_q;
        num_d        = num_q;
        bcd_d        = bcd_q;
        bin_d        = bin_q;
        iter_d       = iter_q;
        cnt_d        = cnt_q;
        neg_d        = neg_q;
        busy_d       = busy_q;
        err_d        = err_q;
        clear_s      = 1'b0;
        new_a_s      = 1'b0;

        case (state_q)
            ENTER_A, ENTER_B: begin
                if (event_s && is_clr_s) begin
                    clear_s = 1'b1;
                end else if (event_s && is_digit_s && digit_ok_s) begin
                    num_d = {num_q[35:0], digit_s};
                    cnt_d = cnt_q + 4'd1;
                    a_d   = (state_q == ENTER_A) ? (a_q * 36'sd10 + $signed({32'd0, digit_s})) : a_q;
                    b_d   = (state_q == ENTER_B) ? (b_q * 30'd10 + {26'd0, digit_s}) : b_q;
                end else if (event_s && is_op_s && (state_q == ENTER_A)) begin
                    op_sub_d = (clickedMatrix == 5'd11);
                    state_d  = OP;
                end else if (event_s && is_eq_s && (state_q == ENTER_B)) begin
                    state_d = CONV;
                    busy_d  = 1'b1;
                    iter_d  = 6'd0;
                end else begin
                    state_d = state_q;
                end
            end
            OP: begin
                if (event_s && is_clr_s) begin
                    clear_s = 1'b1;
                end else if (event_s && is_digit_s) begin
                    num_d   = {36'd0, digit_s};
                    cnt_d   = 4'd1;
                    b_d     = {26'd0, digit_s};
                    state_d = ENTER_B;
                end else if (event_s && is_op_s) begin
                    op_sub_d = (clickedMatrix == 5'd11);
                end else begin
                    state_d = state_q;
                end
            end
            // Key events are intentionally not decoded here, so even 'C' is lost while converting.
            CONV: begin
                if (iter_q == 6'd0) begin
                    res_d = sum_s;
                    if (ovf_s) begin
                        state_d = ERR;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        num_d   = 40'd0;
                        cnt_d   = 4'd0;
                        neg_d   = 1'b0;
                    end else begin
                        bin_d  = mag_s[33:0];
                        bcd_d  = 40'd0;
                        iter_d = 6'd1;
                    end
                end else if (iter_q <= LAST_ITER) begin
                    bcd_d  = dabble_step(bcd_q, bin_q[33]);
                    bin_d  = {bin_q[32:0], 1'b0};
                    iter_d = iter_q + 6'd1;
                end else begin
                    num_d   = bcd_q;
                    cnt_d   = sig_digits(bcd_q);
                    neg_d   = SUB_EN & res_q[35];
                    busy_d  = 1'b0;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (event_s && is_clr_s) begin
                    clear_s = 1'b1;
                end else if (event_s && is_digit_s) begin
                    new_a_s = 1'b1;
                end else if (event_s && is_op_s) begin
                    a_d      = res_q;
                    op_sub_d = (clickedMatrix == 5'd11);
                    state_d  = OP;
                end else begin
                    state_d = state_q;
                end
            end
            ERR: begin
                if (event_s && is_clr_s) begin
                    clear_s = 1'b1;
                end else if (event_s && is_digit_s) begin
                    new_a_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                clear_s = 1'b1;
            end
        endcase

        if (clear_s || new_a_s) begin
            state_d  = ENTER_A;
            a_d      = new_a_s ? $signed({32'd0, digit_s}) : 36'sd0;
            b_d      = 30'd0;
            res_d    = 36'sd0;
            op_sub_d = 1'b0;
            num_d    = new_a_s ? {36'd0, digit_s} : 40'd0;
            cnt_d    = (new_a_s && (digit_s != 4'd0)) ? 4'd1 : 4'd0;
            neg_d    = 1'b0;
            busy_d   = 1'b0;
            err_d    = 1'b0;
            iter_d   = 6'd0;
            bin_d    = 34'd0;
            bcd_d    = 40'd0;
        end else begin
            click_prev_d = clicked;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK_100MHZ or negedge reset) begin
        if (!reset) begin
            state_q      <= ENTER_A;
            click_prev_q <= 1'b0;
            a_q          <= 36'sd0;
            b_q          <= 30'd0;
            res_q        <= 36'sd0;
            op_sub_q     <= 1'b0;
            num_q        <= 40'd0;
            bcd_q        <= 40'd0;
            bin_q        <= 34'd0;
            iter_q       <= 6'd0;
            cnt_q        <= 4'd0;
            neg_q        <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            click_prev_q <= click_prev_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            op_sub_q     <= op_sub_d;
            num_q        <= num_d;
            bcd_q        <= bcd_d;
            bin_q        <= bin_d;
            iter_q       <= iter_d;
            cnt_q        <= cnt_d;
            neg_q        <= neg_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign numActual    = num_q;
    assign counterTotal = cnt_q;
    assign negative     = neg_q;
    assign busy         = busy_q;
    assign error        = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: keys are pressed, expected results queued, compared when busy drops.
module tb_calc_sequencer;

    logic        clk;
    logic        reset;
    logic        clicked;
    logic [4:0]  clickedMatrix;
    logic [39:0] numActual;
    logic [3:0]  counterTotal;
    logic        negative, busy, error;

    int vectors     = 0;
    int miscompares = 0;
    longint acc;

    typedef struct {
        logic [39:0] num;
        logic [3:0]  cnt;
        logic        neg;
        logic        err;
        int          blen;
    } exp_t;
    exp_t sb_q[$];

    calc_sequencer #(.MAX_DIGITS(9)) dut (
        .CLK_100MHZ   (clk),
        .reset        (reset),
        .clicked      (clicked),
        .clickedMatrix(clickedMatrix),
        .numActual    (numActual),
        .counterTotal (counterTotal),
        .negative     (negative),
        .busy         (busy),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish within 500000 ns");
        $fatal(1, "timeout");
    end

    // Decimal digit extraction by division, independent of shift-add-3.
    function automatic logic [39:0] dec_bcd(input longint unsigned v);
        logic [39:0] r;
        r = 40'd0;
        for (int i = 0; i < 10; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] dec_len(input longint unsigned v);
        logic [3:0] n;
        n = 4'd1;
        while (v >= 10) begin
            v = v / 10;
            n = n + 4'd1;
        end
        return n;
    endfunction

    task automatic press(input logic [4:0] k);
        @(negedge clk);
        clickedMatrix = k;
        clicked = 1'b1;
        @(negedge clk);
        clicked = 1'b0;
    endtask

    task automatic enter_num(input longint unsigned v);
        int d[$];
        do begin
            d.push_front(int'(v % 10));
            v = v / 10;
        end while (v != 0);
        foreach (d[i]) press(5'(d[i]));
    endtask

    task automatic check_disp(input string name, input logic [39:0] en, input logic [3:0] ec);
        vectors += 2;
        if (numActual !== en) begin
            miscompares++;
            $display("FAIL %s numActual: got %h expected %h", name, numActual, en);
        end
        if (counterTotal !== ec) begin
            miscompares++;
            $display("FAIL %s counterTotal: got %0d expected %0d", name, counterTotal, ec);
        end
    endtask

    task automatic wait_result(input string name, input bit inject_clr);
        int n;
        exp_t e;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (inject_clr && n == 3) begin
                clickedMatrix = 5'd13;
                clicked = 1'b1;
            end
            if (inject_clr && n == 5) clicked = 1'b0;
            @(negedge clk);
        end
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", name);
        end else begin
            e = sb_q.pop_front();
            if (n !== e.blen) begin
                miscompares++;
                $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, e.blen);
            end
            check_disp(name, e.num, e.cnt);
            vectors += 2;
            if (negative !== e.neg) begin
                miscompares++;
                $display("FAIL %s negative: got %b expected %b", name, negative, e.neg);
            end
            if (error !== e.err) begin
                miscompares++;
                $display("FAIL %s error: got %b expected %b", name, error, e.err);
            end
        end
    endtask

    task automatic do_equals(input string name, input longint res, input bit inject_clr);
        exp_t e;
        longint unsigned m;
        m = (res < 0) ? longint'(-res) : res;
        if (m > 64'd9999999999) begin
            e.num = 40'd0; e.cnt = 4'd0; e.neg = 1'b0; e.err = 1'b1; e.blen = 1;
        end else begin
            e.num = dec_bcd(m); e.cnt = dec_len(m); e.neg = (res < 0); e.err = 1'b0; e.blen = 36;
        end
        sb_q.push_back(e);
        press(5'd12);
        wait_result(name, inject_clr);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clicked = 1'b0;
        clickedMatrix = 5'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_disp("reset", 40'd0, 4'd0);
        vectors += 3;
        if (negative !== 1'b0) begin miscompares++; $display("FAIL reset negative: got %b expected 0", negative); end
        if (busy !== 1'b0)     begin miscompares++; $display("FAIL reset busy: got %b expected 0", busy); end
        if (error !== 1'b0)    begin miscompares++; $display("FAIL reset error: got %b expected 0", error); end
    endtask

    task automatic test_add();
        press(5'd13);
        press(5'd1); press(5'd2);
        check_disp("add_a", 40'h12, 4'd2);
        press(5'd10);
        press(5'd3); press(5'd4);
        check_disp("add_b", 40'h34, 4'd2);
        do_equals("add_res", 64'sd46, 1'b0);
    endtask

    task automatic test_max_digits();
        press(5'd13);
        press(5'd0);
        check_disp("lead_zero", 40'd0, 4'd0);
        repeat (10) press(5'd9);
        press(5'd0);
        check_disp("max_digits", 40'h999999999, 4'd9);
    endtask

    task automatic test_sub();
        press(5'd13);
        press(5'd3); press(5'd11); press(5'd5);
`ifdef CALC_SUB_EN
        check_disp("sub_b", 40'h5, 4'd1);
        do_equals("sub_res", -64'sd2, 1'b0);
`else
        check_disp("sub_ignored", 40'h35, 4'd2);
        press(5'd12);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL eq_in_enter_a busy: got %b expected 0", busy);
        end
        check_disp("eq_in_enter_a", 40'h35, 4'd2);
`endif
    endtask

    task automatic test_ignored_keys();
        press(5'd13);
        press(5'd5);
        press(5'd20); press(5'd31); press(5'd14); press(5'd12);
        check_disp("ignored_keys", 40'h5, 4'd1);
    endtask

    task automatic test_chain();
        press(5'd13);
        enter_num(64'd999999999);
        press(5'd10);
        enter_num(64'd999999999);
        do_equals("chain1", 64'sd1999999998, 1'b0);
        press(5'd10); press(5'd5);
        do_equals("chain2", 64'sd2000000003, 1'b0);
        acc = 64'sd2000000003;
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 9; k++) begin
            press(5'd10);
            enter_num(64'd999999999);
            acc = acc + 64'sd999999999;
            do_equals("ovf_chain", acc, 1'b0);
        end
        press(5'd10); press(5'd12);
        vectors += 2;
        if (error !== 1'b1) begin miscompares++; $display("FAIL err_hold error: got %b expected 1", error); end
        if (busy !== 1'b0)  begin miscompares++; $display("FAIL err_hold busy: got %b expected 0", busy); end
        press(5'd7);
        check_disp("err_digit", 40'h7, 4'd1);
        vectors++;
        if (error !== 1'b0) begin miscompares++; $display("FAIL err_digit error: got %b expected 0", error); end
    endtask

    task automatic test_held_click();
        press(5'd13);
        @(negedge clk);
        clickedMatrix = 5'd4;
        clicked = 1'b1;
        repeat (100) @(negedge clk);
        clicked = 1'b0;
        check_disp("held_click", 40'h4, 4'd1);
        press(5'd5);
        check_disp("after_held", 40'h45, 4'd2);
    endtask

    task automatic test_clear_during_busy();
        press(5'd13);
        press(5'd1); press(5'd10); press(5'd2);
        do_equals("clr_in_busy", 64'sd3, 1'b1);
    endtask

    task automatic test_reset_mid_conv();
        press(5'd13);
        press(5'd8); press(5'd10); press(5'd9);
        press(5'd12);
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_disp("rst_mid", 40'd0, 4'd0);
        vectors += 3;
        if (busy !== 1'b0)     begin miscompares++; $display("FAIL rst_mid busy: got %b expected 0", busy); end
        if (error !== 1'b0)    begin miscompares++; $display("FAIL rst_mid error: got %b expected 0", error); end
        if (negative !== 1'b0) begin miscompares++; $display("FAIL rst_mid negative: got %b expected 0", negative); end
        clickedMatrix = 5'd6;
        clicked = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_disp("held_over_reset", 40'h6, 4'd1);
        repeat (10) @(negedge clk);
        clicked = 1'b0;
        check_disp("held_over_reset2", 40'h6, 4'd1);
    endtask

    initial begin
        test_reset();
        test_add();
        test_max_digits();
        test_sub();
        test_ignored_keys();
        test_chain();
        test_overflow();
        test_held_click();
        test_clear_during_busy();
        test_reset_mid_conv();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
